// File: rtl/fabric_pkg.sv
// Shared types and defaults for the redundant request fabric.
package fabric_pkg;

    typedef struct packed {
        logic faulty_hdr;
        logic faulty_payload;
    } rfab_redund_sel_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2,
        ACK    = 2'd3
    } fab_sched_state_e;

    localparam int unsigned FAB_SCHED_STARVE_LIM_DEF = 16;

endpackage

// File: rtl/fabric_redund_sched_if.sv
// Request/grant and redundancy-configuration bus of the fabric scheduler.
interface fabric_redund_sched_if #(
    parameter int unsigned NBL = 4
);
    import fabric_pkg::*;

    localparam int unsigned PW = $clog2(NBL);

    logic [NBL-1:0]   req;
    logic [NBL-1:0]   gnt;
    logic [PW-1:0]    sel;
    logic             sel_vld;
    logic             cfg_req;
    rfab_redund_sel_t cfg_rsel;
    logic             cfg_ack;
    rfab_redund_sel_t rsel;
    logic             busy;
    logic             starve;

    modport master (
        output req, cfg_req, cfg_rsel,
        input  gnt, sel, sel_vld, cfg_ack, rsel, busy, starve
    );

    modport slave (
        input  req, cfg_req, cfg_rsel,
        output gnt, sel, sel_vld, cfg_ack, rsel, busy, starve
    );

endinterface

// File: rtl/fabric_rr_arb.sv
// Combinational NBL-way round-robin search starting at ptr, wrapping NBL-1 -> 0.
module fabric_rr_arb #(
    parameter int unsigned NBL = 4,
    parameter int unsigned PW  = $clog2(NBL)
) (
    input  logic [NBL-1:0] req,
    input  logic [PW-1:0]  ptr,
    output logic [NBL-1:0] win_oh,
    output logic [PW-1:0]  win_idx,
    output logic           any
);

    // First set request at or after ptr wins.
    always_comb begin
        int unsigned idx;
        win_oh  = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < NBL; k++) begin
            idx = (32'(ptr) + k) % NBL;
            if (!any && req[PW'(idx)]) begin
                any              = 1'b1;
                win_oh[PW'(idx)] = 1'b1;
                win_idx          = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/fabric_redund_sched.sv
// Round-robin fabric scheduler that drains the mux pipeline around every rsel change.
// Optional starvation monitor enabled by defining FABRIC_REDUND_SCHED_STARVE_EN.
module fabric_redund_sched
    import fabric_pkg::*;
#(
    parameter int unsigned NBL        = 4,
    parameter int unsigned LATENCY    = 2,
    parameter int unsigned STARVE_LIM = FAB_SCHED_STARVE_LIM_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    fabric_redund_sched_if.slave        bus
);

    localparam int unsigned PW = $clog2(NBL);
    localparam int unsigned CW = $clog2(LATENCY + 1);

    fab_sched_state_e state_q, state_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [NBL-1:0]   gnt_q, gnt_d;
    logic [PW-1:0]    sel_q, sel_d;
    logic             sel_vld_q, sel_vld_d;
    logic             cfg_ack_q, cfg_ack_d;
    logic             busy_q, busy_d;
    rfab_redund_sel_t rsel_q, rsel_d;

    logic [NBL-1:0]   arb_oh;
    logic [PW-1:0]    arb_idx;
    logic             arb_any;

    fabric_rr_arb #(.NBL(NBL), .PW(PW)) u_arb (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_oh  (arb_oh),
        .win_idx (arb_idx),
        .any     (arb_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            ptr_q     <= '0;
            cnt_q     <= '0;
            gnt_q     <= '0;
            sel_q     <= '0;
            sel_vld_q <= 1'b0;
            cfg_ack_q <= 1'b0;
            busy_q    <= 1'b0;
            rsel_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            sel_vld_q <= sel_vld_d;
            cfg_ack_q <= cfg_ack_d;
            busy_q    <= busy_d;
            rsel_q    <= rsel_d;
        end
    end

    // Registered outputs are computed for the state being entered, so they line up with it.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = '0;
        sel_d     = sel_q;
        sel_vld_d = 1'b0;
        cfg_ack_d = 1'b0;
        rsel_d    = rsel_q;
        case (state_q)
            RUN: begin
                if (bus.cfg_req) begin
                    state_d = DRAIN;
                    cnt_d   = CW'(LATENCY);
                end else if (arb_any) begin
                    gnt_d     = arb_oh;
                    sel_d     = arb_idx;
                    sel_vld_d = 1'b1;
                    ptr_d     = (arb_idx == PW'(NBL - 1)) ? '0 : arb_idx + PW'(1);
                end
            end
            DRAIN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = SWITCH;
                    rsel_d  = bus.cfg_rsel;
                end
            end
            SWITCH: begin
                state_d   = ACK;
                cfg_ack_d = 1'b1;
            end
            ACK: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        busy_d = (state_d != RUN);
    end

    assign bus.gnt     = gnt_q;
    assign bus.sel     = sel_q;
    assign bus.sel_vld = sel_vld_q;
    assign bus.cfg_ack = cfg_ack_q;
    assign bus.busy    = busy_q;
    assign bus.rsel    = rsel_q;

`ifdef FABRIC_REDUND_SCHED_STARVE_EN
    localparam int unsigned SW = $clog2(STARVE_LIM + 1);

    logic [SW-1:0] wait_q [NBL];
    logic          starve_q;
    logic          starve_hit_c;

    always_comb begin
        starve_hit_c = 1'b0;
        for (int unsigned i = 0; i < NBL; i++) begin
            if (wait_q[i] == SW'(STARVE_LIM)) starve_hit_c = 1'b1;
        end
    end

    // Saturating per-requester wait counters; starve is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NBL; i++) wait_q[i] <= '0;
            starve_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NBL; i++) begin
                if (bus.req[i] && !gnt_q[i]) begin
                    if (wait_q[i] != SW'(STARVE_LIM)) wait_q[i] <= wait_q[i] + SW'(1);
                end else begin
                    wait_q[i] <= '0;
                end
            end
            starve_q <= starve_q | starve_hit_c;
        end
    end

    assign bus.starve = starve_q;
`else
    assign bus.starve = 1'b0;
`endif

endmodule
